display_formatter: RTL and testbench
====================================

# display_formatter

Converts a binary result from the matrix multiplier into four BCD digits and drives the segment lines of the 4-digit seven-segment display. It sits directly downstream of `digit_selector`: it consumes the rotating active-low anode pattern `digit_sel` and, in the same cycle, presents the segment pattern for the digit that pattern enables. Binary-to-BCD conversion is sequential shift-add-3 (double-dabble), one bit per clock. The visible value changes only on a commit, so the display never shows a half-converted number.

## Interface
- `IN_W`, default 14: binary input width; legal range 4..14.
- `clkd`  input  1: display clock, shared with `digit_selector`.
- `rst`  input  1: synchronous, active-low reset.
- `load`  input  1: single-cycle request to convert `value`.
- `value`  input  IN_W: unsigned binary number to display.
- `digit_sel`  input  4: active-low one-hot anode select from `digit_selector`.
- `seg`  output  7: `{g,f,e,d,c,b,a}`, active-low.
- `busy`  output  1: conversion in progress.
- `done`  output  1: one-cycle pulse when the display register is committed.
- `ovf`  output  1: the last committed value was greater than 9999.

## Operation
- FSM states:
  - IDLE: accepts `load`.
  - SHIFT: performs `IN_W` iterations.
  - COMMIT: lasts 1 cycle.
- IDLE, `load`=1:
  - If `value` ≤ 9999: capture `value` into the shift register, clear the 16-bit BCD accumulator and the iteration counter, then go to SHIFT.
  - If `value` > 9999: set the overflow flag and go straight to COMMIT.
- SHIFT, each edge:
  - For each BCD nibble ≥ 5, add 3 to that nibble.
  - Shift `{bcd, shreg}` left by 1.
  - Increment the counter; after the `IN_W`-th shift, go to COMMIT.
- COMMIT:
  - Copy the BCD accumulator into the 16-bit display register, or the dash pattern if overflow.
  - Set `ovf` = overflow, pulse `done`, return to IDLE.
- `load` while `busy`=1 is ignored; there is no queuing.
- Segment decode is combinational from `digit_sel` and the display register:
  - `1110` → ones; `1101` → tens; `1011` → hundreds; `0111` → thousands.
  - Any other pattern → `seg`=`1111111`.
- Digit codes:
  - 0 `1000000`, 1 `1111001`, 2 `0100100`, 3 `0110000`, 4 `0011001`
  - 5 `0010010`, 6 `0000010`, 7 `1111000`, 8 `0000000`, 9 `0010000`
- Overflow shows a dash (`0111111`) on every digit.

## Timing
- Reset (`rst`=0 at an edge):
  - State IDLE; display register 0; `busy`=0, `done`=0, `ovf`=0.
  - Result: "0000" (or "   0", see Configuration).
- Reset wins over a simultaneous `load`.
- Reset mid-conversion aborts it; the display register goes to 0.
- Let edge E0 be the edge that samples `load`=1 in IDLE.
  - Valid value:
    - `busy`=1 from after E0 through E(`IN_W`+1).
    - Display register and `done`=1 valid after E(`IN_W`+1).
    - `busy`=0 in that same cycle.
    - Latency is `IN_W`+1 edges (15 at default).
  - Overflow value: COMMIT at E1, so latency is 1 edge.
- `done` is high for exactly one cycle.
- A new `load` is accepted in the cycle where `done`=1, because the state is already IDLE.
- `seg` has zero-cycle latency from `digit_sel`: no ghosting when `digit_selector` advances.
- The old value stays displayed throughout a conversion.

## Configuration
- `DISP_LZ_BLANK_EN` defined:
  - Leading zero digits in thousands/hundreds/tens are blanked (`1111111`).
  - Blanking stops at the first non-zero digit.
  - The ones digit is always shown.
  - Dashes are never blanked.
- Undefined: all four digits are always shown, including leading zeros.

## Test plan
- Reset, then `digit_sel`=`1110` → `seg`=`1000000`, `busy`=0, `done`=0, `ovf`=0.
- Load 1234 → `done` 15 edges later.
  - `1110`→`0011001`, `1101`→`0110000`, `1011`→`0100100`, `0111`→`1111001`.
- Load 10000 → `done` after 1 edge, `ovf`=1, every digit `0111111`.
  - Then load 9999 → `ovf`=0, every digit `0010000`.
- Load 42; pulse `load`=5678 at E3 while `busy`, then let the 42 conversion finish → the display shows 0042.
  - The 5678 request is ignored.
  - `digit_sel`=`1001` → `1111111`.
- Load 4321; assert `rst`=0 at E7 → display 0, `busy`=0, no `done` pulse.
- Load 7 → thousands `1111111` with `DISP_LZ_BLANK_EN`, `1000000` without; ones `1111000` in both builds.

Source files
------------

// File: rtl/display_formatter_if.sv
// Handshake and display lines between the display formatter and its neighbours.
// master drives the conversion request and anode select; slave returns segments and status.
interface display_formatter_if #(
    parameter int IN_W = 14
) ();
    logic            load;
    logic [IN_W-1:0] value;
    logic [3:0]      digit_sel;
    logic [6:0]      seg;
    logic            busy;
    logic            done;
    logic            ovf;

    modport master (
        output load, value, digit_sel,
        input  seg, busy, done, ovf
    );

    modport slave (
        input  load, value, digit_sel,
        output seg, busy, done, ovf
    );
endinterface

// File: rtl/display_formatter.sv
// Binary to 4-digit BCD (double-dabble, one bit per clock) driving a 7-segment display; DISP_LZ_BLANK_EN blanks leading zeros.
// Latency: IN_W+1 clkd edges from load to done (1 edge for values above 9999); seg is combinational from digit_sel.
// Backpressure: none; load while busy is dropped, the previous value stays displayed until commit.
module display_formatter #(
    parameter int IN_W = 14
) (
    input  logic               clkd,
    input  logic               rst,
    display_formatter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [3:0]  LAST   = 4'(IN_W - 1);
    // Nibble 0xA never occurs in valid BCD, so it marks a dash digit.
    localparam logic [15:0] DASHES = 16'hAAAA;

    state_t          state, state_nxt;
    logic [IN_W-1:0] shreg;
    logic [15:0]     bcd, bcd_adj, disp;
    logic [3:0]      cnt;
    logic            ovf_pend, ovf_r, done_r;
    logic            too_big;
    logic [6:0]      seg_w;
    logic            blank_th, blank_hu, blank_te;

    assign too_big = 32'(bus.value) > 32'd9999;

    always_ff @(posedge clkd) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = too_big ? COMMIT : SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clkd) begin
        if (!rst) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            disp     <= '0;
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        ovf_pend <= too_big;
                        shreg    <= bus.value;
                        bcd      <= '0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, shreg} <= {bcd_adj[14:0], shreg, 1'b0};
                    cnt          <= cnt + 4'd1;
                end
                COMMIT: begin
                    disp   <= ovf_pend ? DASHES : bcd;
                    ovf_r  <= ovf_pend;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'hA:    return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
`ifdef DISP_LZ_BLANK_EN
        blank_th = (disp[15:12] == 4'd0);
        blank_hu = blank_th && (disp[11:8] == 4'd0);
        blank_te = blank_hu && (disp[7:4] == 4'd0);
`else
        blank_th = 1'b0;
        blank_hu = 1'b0;
        blank_te = 1'b0;
`endif
        seg_w = 7'b1111111;
        case (bus.digit_sel)
            4'b1110: seg_w = seg7(disp[3:0]);
            4'b1101: seg_w = blank_te ? 7'b1111111 : seg7(disp[7:4]);
            4'b1011: seg_w = blank_hu ? 7'b1111111 : seg7(disp[11:8]);
            4'b0111: seg_w = blank_th ? 7'b1111111 : seg7(disp[15:12]);
            default: seg_w = 7'b1111111;
        endcase
    end

    assign bus.seg  = seg_w;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_display_formatter.sv
// Scoreboard bench for display_formatter: requests queued at load, checked against the commit pulse.
module tb_display_formatter;
    localparam int IN_W = 14;

    typedef struct {
        int v;
        int e0;
    } exp_t;

    logic clkd = 1'b0;
    logic rst  = 1'b0;
    int   cyc  = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    display_formatter_if #(.IN_W(IN_W)) bus ();

    display_formatter #(.IN_W(IN_W)) dut (
        .clkd (clkd),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clkd = ~clkd;
    always @(posedge clkd) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int v, input int k);
        int p = 1;
        int d;
        if (v > 9999) return 7'b0111111;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (v / p) % 10;
`ifdef DISP_LZ_BLANK_EN
        if (k > 0 && v < p) return 7'b1111111;
`endif
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic chk_disp(input int v, input string tag);
        logic [3:0] one = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            bus.digit_sel = ~(one << k);
            #1;
            chk_val($sformatf("%s_seg%0d", tag, k), 32'(bus.seg), 32'(ref_seg(v, k)));
        end
    endtask

    task automatic do_load(input int v, input string tag);
        bus.value = IN_W'(v);
        bus.load  = 1'b1;
        sb.push_back('{v: v, e0: cyc + 1});
        @(negedge clkd);
        bus.load = 1'b0;
        chk_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int   n = 0;
        exp_t e;
        while (!bus.done && n < 40) begin
            @(negedge clkd);
            n++;
        end
        if (!bus.done) begin
            chk_val({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk_val({tag, "_lat"}, 32'(cyc - e.e0), (e.v > 9999) ? 32'd1 : 32'(IN_W + 1));
            chk_val({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
            chk_val({tag, "_ovf"}, 32'(bus.ovf), (e.v > 9999) ? 32'd1 : 32'd0);
            chk_disp(e.v, tag);
        end
    endtask

    task automatic no_done(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clkd);
            if (bus.done) seen++;
        end
        chk_val(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load      = 1'b0;
        bus.value     = '0;
        bus.digit_sel = 4'b1110;
        repeat (3) @(negedge clkd);
        rst = 1'b1;
        #1;
        chk_val("rst_seg", 32'(bus.seg), 32'h40);
        chk_val("rst_busy", 32'(bus.busy), 32'd0);
        chk_val("rst_done", 32'(bus.done), 32'd0);
        chk_val("rst_ovf", 32'(bus.ovf), 32'd0);
        chk_disp(0, "rst");
        @(negedge clkd);

        do_load(1234, "l1234");
        wait_done("l1234");
        @(negedge clkd);
        chk_val("done_pulse", 32'(bus.done), 32'd0);

        // Overflow then a back-to-back load in the done cycle.
        do_load(10000, "l10000");
        wait_done("l10000");
        do_load(9999, "l9999");
        wait_done("l9999");

        @(negedge clkd);
        do_load(42, "l42");
        repeat (2) @(negedge clkd);
        bus.value = IN_W'(5678);
        bus.load  = 1'b1;
        @(negedge clkd);
        bus.load = 1'b0;
        wait_done("l42");
        no_done(20, "ignored_load");
        chk_disp(42, "after_ignore");
        bus.digit_sel = 4'b1001;
        #1;
        chk_val("bad_sel", 32'(bus.seg), 32'h7F);

        @(negedge clkd);
        do_load(4321, "l4321");
        repeat (6) @(negedge clkd);
        rst = 1'b0;
        void'(sb.pop_front());
        @(negedge clkd);
        rst = 1'b1;
        chk_val("abort_busy", 32'(bus.busy), 32'd0);
        chk_val("abort_done", 32'(bus.done), 32'd0);
        chk_disp(0, "abort");
        no_done(20, "abort_nodone");

        bus.value = IN_W'(55);
        bus.load  = 1'b1;
        rst       = 1'b0;
        @(negedge clkd);
        bus.load = 1'b0;
        rst      = 1'b1;
        chk_val("rst_vs_load_busy", 32'(bus.busy), 32'd0);
        no_done(20, "rst_vs_load_nodone");

        do_load(7, "l7");
        wait_done("l7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
